// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity encodings,
// FSM state type/constants and the baud divider helper.
package uart_pkg;

  // parity_mode encodings; 2'b11 is treated the same as PAR_NONE
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned BAUD_CNT_W = 16;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Clocks per serial bit, truncated; clk_fre is in MHz
  function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                             input int unsigned baud_rate);
    logic [63:0] hz;
    hz = 64'(clk_fre) * 64'd1000000;
    return 32'(hz / 64'(baud_rate));
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port.
// Push while full and pop while empty are ignored. Occupancy flags are
// registered from the next-count value so they never lag a transfer.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_full;
  logic              r_empty;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_push_ok = push && !r_full;
  assign w_pop_ok  = pop && !r_empty;

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointers (wrap naturally, DEPTH is a power of two) and occupancy flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: configurable data width, per-frame parity and
// stop-bit count, busy flag and an input buffer.
// Build option UART_TX_FIFO_EN: defined -> FIFO_DEPTH-entry FIFO buffer;
// undefined -> single holding register (FIFO_DEPTH ignored).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 25,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_data_valid,
  output logic                               tx_data_ready,
  input  logic [1:0]                         parity_mode,
  input  logic                               two_stop,
  output logic                               tx_pin,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(CYCLE - 1);
  localparam logic [BIT_W-1:0]      DATA_LAST = BIT_W'(DATA_BITS - 1);

  // Buffer interface, common to both build options
  logic [DATA_BITS-1:0] w_buf_dout;
  logic                 w_buf_empty;
  logic [CNT_W-1:0]     w_occ;
  logic [CNT_W-1:0]     w_occ_nxt;
  logic                 w_push;
  logic                 w_pop;

  // Transmit datapath and control
  state_t                r_state;
  state_t                w_state_nxt;
  logic [BAUD_CNT_W-1:0] r_baud_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_two_stop;
  logic                  r_tx_pin;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_avail;
  logic                  w_baud_end;
  logic                  w_stop_last;
  logic                  w_frame_end;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned OCC_MAX = FIFO_DEPTH;

  logic w_fifo_full;

  assign w_push = tx_data_valid && r_ready && !w_fifo_full;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_buf_dout),
    .full  (w_fifo_full),
    .empty (w_buf_empty),
    .count (w_occ)
  );
`else
  localparam int unsigned OCC_MAX = 1;

  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;

  assign w_push = tx_data_valid && r_ready;

  // Single holding register; reloads while the shift latch is still sending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_push) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
    end else if (w_pop) begin
      r_hold_full <= 1'b0;
    end
  end

  assign w_buf_dout  = r_hold;
  assign w_buf_empty = !r_hold_full;
  assign w_occ       = CNT_W'(r_hold_full);
`endif

  // Occupancy after this edge; drives the registered ready flag
  always_comb begin
    w_occ_nxt = w_occ;
    if (w_push && !w_pop) begin
      w_occ_nxt = w_occ + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_occ_nxt = w_occ - CNT_W'(1);
    end
  end

  assign w_baud_end  = (r_baud_cnt == BAUD_LAST);
  assign w_stop_last = (r_bit_cnt == BIT_W'(r_two_stop));
  assign w_frame_end = (r_state == ST_STOP) && w_baud_end && w_stop_last;

  // A word is started only once its arrival has been seen through r_avail,
  // which gives the two-edge handshake-to-start-bit latency.
  assign w_pop = r_avail && !w_buf_empty &&
                 ((r_state == ST_IDLE) || w_frame_end);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_baud_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_baud_end && (r_bit_cnt == DATA_LAST)) begin
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_baud_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_frame_end) w_state_nxt = w_pop ? ST_START : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Baud counter: held at zero in IDLE, reloads on every bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud_cnt <= '0;
    end else if ((r_state == ST_IDLE) || w_baud_end) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + BAUD_CNT_W'(1);
    end
  end

  // Frame datapath: word/option latch on pop, then bit-by-bit serialisation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_tx_pin   <= 1'b1;
    end else if (w_pop) begin
      r_shift    <= w_buf_dout;
      r_bit_cnt  <= '0;
      r_par_en   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      r_par_bit  <= (^w_buf_dout) ^ (parity_mode == PAR_ODD);
      r_two_stop <= two_stop;
      r_tx_pin   <= 1'b0;
    end else if (w_baud_end && (r_state != ST_IDLE)) begin
      case (r_state)
        ST_START: begin
          r_tx_pin  <= r_shift[0];
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= '0;
        end
        ST_DATA: begin
          if (r_bit_cnt == DATA_LAST) begin
            r_bit_cnt <= '0;
            r_tx_pin  <= r_par_en ? r_par_bit : 1'b1;
          end else begin
            r_tx_pin  <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
        end
        ST_PARITY: begin
          r_tx_pin  <= 1'b1;
          r_bit_cnt <= '0;
        end
        ST_STOP: begin
          r_tx_pin <= 1'b1;
          if (w_stop_last) r_bit_cnt <= '0;
          else             r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
        default: r_tx_pin <= 1'b1;
      endcase
    end
  end

  // Handshake, availability and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_avail <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= (w_occ_nxt != CNT_W'(OCC_MAX));
      r_avail <= !w_buf_empty;
      r_busy  <= (r_state != ST_IDLE) || (w_occ != '0);
    end
  end

  assign tx_data_ready = r_ready;
  assign tx_pin        = r_tx_pin;
  assign busy          = r_busy;
  assign fifo_count    = w_occ;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (default 8-bit instance plus a 5-bit one).
module tb_uart_tx_fifo;

  localparam int C = 217;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_pin;
  logic       busy;
  logic [4:0] fifo_count;

  logic [4:0] tx_data5;
  logic       valid5;
  logic       ready5;
  logic [1:0] pm5;
  logic       ts5;
  logic       pin5;
  logic       busy5;
  logic [4:0] cnt5;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;

  always #5 clk = ~clk;

  uart_tx_fifo u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready), .parity_mode(parity_mode), .two_stop(two_stop),
    .tx_pin(tx_pin), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.DATA_BITS(5)) u_dut5 (
    .clk(clk), .rst(rst), .tx_data(tx_data5), .tx_data_valid(valid5),
    .tx_data_ready(ready5), .parity_mode(pm5), .two_stop(ts5),
    .tx_pin(pin5), .busy(busy5), .fifo_count(cnt5)
  );

  always @(posedge clk) begin
    if (tx_data_valid && tx_data_ready) n_acc <= n_acc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pin(input bit sel);
    return sel ? pin5 : tx_pin;
  endfunction

  // Present one word and hold it until the handshake edge has passed
  task automatic push(input bit sel, input logic [7:0] d);
    int guard = 0;
    @(negedge clk);
    if (sel) begin tx_data5 = d[4:0]; valid5 = 1'b1; end
    else     begin tx_data  = d;      tx_data_valid = 1'b1; end
    while (!(sel ? ready5 : tx_data_ready) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready", 32'(guard < 5000), 32'd1);
    @(negedge clk);
    if (sel) valid5 = 1'b0;
    else     tx_data_valid = 1'b0;
  endtask

  // Returns at the first negedge where the pin is low
  task automatic wait_start(input bit sel, input int bound);
    int n = 0;
    while (pin(sel) !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(n < bound), 32'd1);
  endtask

  // Called at the negedge after the start-bit edge; checks first and last
  // clock of every bit, returns at the negedge after the frame-end edge
  task automatic check_frame(input string tag, input bit sel, input int db,
                             input logic [8:0] d, input int par, input int stops);
    logic [15:0] bits;
    logic        p;
    int          n;
    bits = '0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < db; i++) begin
      bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (par != 0) begin
      bits[n] = (par == 2) ? ~p : p;
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      bits[n] = 1'b1;
      n++;
    end
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_b%0d_first", tag, k), 32'(pin(sel)), 32'(bits[k]));
      repeat (C - 1) @(negedge clk);
      check($sformatf("%s_b%0d_last", tag, k), 32'(pin(sel)), 32'(bits[k]));
      @(negedge clk);
    end
  endtask

  // Push into an idle block and check the two-edge start latency
  task automatic send_idle(input string tag, input logic [7:0] d);
    push(1'b0, d);
    check({tag, "_cnt"}, 32'(fifo_count), 32'd1);
    check({tag, "_rdy"}, 32'(tx_data_ready), 32'(FIFO));
    @(negedge clk);
    check({tag, "_lat1"}, 32'(tx_pin), 32'd1);
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_lat2"}, 32'(tx_pin), 32'd0);
  endtask

  task automatic check_end(input string tag);
    check({tag, "_idle_pin"}, 32'(tx_pin), 32'd1);
    check({tag, "_busy_hold"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acc_base;
    int lows;
    int nw;
    rst = 1'b1;
    tx_data = '0; tx_data_valid = 1'b0; parity_mode = 2'b00; two_stop = 1'b0;
    tx_data5 = '0; valid5 = 1'b0; pm5 = 2'b00; ts5 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pin", 32'(tx_pin), 32'd1);
    check("rst_ready", 32'(tx_data_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    #1 check("rel_ready_low", 32'(tx_data_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_high", 32'(tx_data_ready), 32'd1);

    // 1: plain 8N1 frame of 0x41
    send_idle("t1", 8'h41);
    check_frame("t1", 1'b0, 8, 9'h041, 0, 1);
    check_end("t1");

    // 2: even, odd parity, then two stop bits
    parity_mode = 2'b01;
    send_idle("t2e", 8'h41);
    check_frame("t2e", 1'b0, 8, 9'h041, 1, 1);
    check_end("t2e");
    parity_mode = 2'b10;
    send_idle("t2o", 8'h41);
    check_frame("t2o", 1'b0, 8, 9'h041, 2, 1);
    check_end("t2o");
    parity_mode = 2'b00;
    two_stop = 1'b1;
    send_idle("t2s", 8'h41);
    check_frame("t2s", 1'b0, 8, 9'h041, 0, 2);
    check_end("t2s");
    two_stop = 1'b0;

`ifdef UART_TX_FIFO_EN
    // 3: streaming 20 words through the FIFO
    acc_base = n_acc;
    fork
      begin
        int i = 0;
        int g = 0;
        int mx = 0;
        logic rdy;
        tx_data_valid = 1'b1;
        while (i < 20 && g < 60000) begin
          tx_data = 8'(i);
          rdy = tx_data_ready;
          if (int'(fifo_count) > mx) mx = int'(fifo_count);
          if (fifo_count == 5'd16) check("t3_full_not_ready", 32'(tx_data_ready), 32'd0);
          @(negedge clk);
          g++;
          if (rdy) i++;
        end
        tx_data_valid = 1'b0;
        check("t3_all_accepted", 32'(i), 32'd20);
        check("t3_max_count", 32'(mx), 32'd16);
      end
      begin
        wait_start(1'b0, 100);
        for (int k = 0; k < 20; k++) begin
          check_frame($sformatf("t3w%0d", k), 1'b0, 8, 9'(k), 0, 1);
          if (k == 0) check("t3_acc_after_pop", 32'(n_acc - acc_base), 32'd17);
        end
      end
    join
    check_end("t3");
`endif

    // 4: parity change mid-frame only affects the following frame
    fork
      begin
        push(1'b0, 8'h41);
        push(1'b0, 8'h57);
      end
      begin
        wait_start(1'b0, 100);
        fork
          check_frame("t4f1", 1'b0, 8, 9'h041, 0, 1);
          begin
            repeat (4 * C) @(negedge clk);
            parity_mode = 2'b01;
          end
        join
        check_frame("t4f2", 1'b0, 8, 9'h057, 1, 1);
      end
    join
    check_end("t4");
    parity_mode = 2'b00;

    // 5: reset in the middle of a frame with words buffered
    nw = FIFO ? 4 : 2;
    fork
      begin
        for (int k = 0; k < nw; k++) push(1'b0, 8'h41);
      end
      wait_start(1'b0, 100);
    join
    repeat (990) @(negedge clk);
    check("t5_pre_pin", 32'(tx_pin), 32'd0);
    check("t5_pre_count", 32'(fifo_count), FIFO ? 32'd3 : 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_pin", 32'(tx_pin), 32'd1);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    check("t5_rst_ready", 32'(tx_data_ready), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t5_rel_ready_low", 32'(tx_data_ready), 32'd0);
    @(negedge clk);
    check("t5_rel_ready_high", 32'(tx_data_ready), 32'd1);
    lows = 0;
    repeat (3000) begin
      @(negedge clk);
      if (tx_pin !== 1'b1) lows++;
    end
    check("t5_silent", 32'(lows), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);

    // 6: 5-bit instance, two words back to back
    fork
      begin
        push(1'b1, 8'h1F);
        push(1'b1, 8'h00);
      end
      begin
        wait_start(1'b1, 100);
        check_frame("t6a", 1'b1, 5, 9'h01F, 0, 1);
        check_frame("t6b", 1'b1, 5, 9'h000, 0, 1);
      end
    join
    check("t6_idle_pin", 32'(pin5), 32'd1);
    @(negedge clk);
    check("t6_busy_off", 32'(busy5), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
